// File: rtl/rv32i_pkg.sv
// Shared RV32I branch-unit types: branch kinds, BR funct3 codes, resolve FSM states
// and the registered result payload.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_BR   = 2'd1,
    KIND_JAL  = 2'd2,
    KIND_JALR = 2'd3
  } br_kind_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } bru_state_e;

  typedef struct packed {
    logic            taken;
    logic            mispredict;
    logic            illegal;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;
  } br_result_t;

endpackage

// File: rtl/comparator_32bit.sv
// 32-bit equality / less-than comparator, signed or unsigned.
module comparator_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_signed,
  output logic        eq_c,
  output logic        lt_c
);

  always_comb begin
    eq_c = (a == b);
    lt_c = is_signed ? ($signed(a) < $signed(b)) : (a < b);
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves branches/jumps, registers one result entry, and raises a redirect on
// mispredict while squashing younger requests until the front end acks it.
module branch_resolve_unit
  import rv32i_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_kind,
  input  logic [2:0]       in_funct3,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic             in_pred_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic             out_mispredict,
  output logic             out_illegal,
  output logic [31:0]      out_target,
  output logic [31:0]      out_link,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ack,
  output logic [CNT_W-1:0] perf_mispredicts
);

  bru_state_e       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  br_result_t       res_q, res_d, res_c;
  logic             redir_valid_q, redir_valid_d;
  logic [31:0]      redir_pc_q, redir_pc_d;
  logic [CNT_W-1:0] perf_q, perf_d;

  br_kind_e    kind;
  logic        cmp_eq, cmp_lt;
  logic [31:0] jalr_sum;
  logic        accept;

  assign kind = br_kind_e'(in_kind);

  comparator_32bit u_cmp (
    .a         (in_rs1),
    .b         (in_rs2),
    .is_signed (~in_funct3[1]),
    .eq_c      (cmp_eq),
    .lt_c      (cmp_lt)
  );

  // Reset gates in_ready so nothing is accepted while rst_n is low.
  assign in_ready = rst_n & ((state_q == ST_SQUASH) | ~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign jalr_sum = in_rs1 + in_imm;

  // Combinational resolution of the presented request.
  always_comb begin
    res_c        = '0;
    res_c.link   = in_pc + 32'd4;
    res_c.target = in_pc + in_imm;
    case (kind)
      KIND_BR: begin
        case (in_funct3)
          F3_BEQ:           res_c.taken = cmp_eq;
          F3_BNE:           res_c.taken = ~cmp_eq;
          F3_BLT, F3_BLTU:  res_c.taken = cmp_lt;
          F3_BGE, F3_BGEU:  res_c.taken = ~cmp_lt;
          default:          res_c.illegal = 1'b1;
        endcase
      end
      KIND_JAL:  res_c.taken = 1'b1;
      KIND_JALR: begin
        res_c.taken  = 1'b1;
        res_c.target = {jalr_sum[31:1], 1'b0};
      end
      default: res_c.taken = 1'b0;
    endcase
    res_c.mispredict = (res_c.taken != in_pred_taken);
  end

  // Next-state, output entry, redirect and counter.
  always_comb begin
    state_d       = state_q;
    out_valid_d   = out_valid_q;
    res_d         = res_q;
    redir_valid_d = redir_valid_q;
    redir_pc_d    = redir_pc_q;
    perf_d        = perf_q;
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          out_valid_d = 1'b1;
          res_d       = res_c;
          if (res_c.mispredict) begin
            redir_valid_d = 1'b1;
            redir_pc_d    = res_c.taken ? res_c.target : res_c.link;
            state_d       = ST_SQUASH;
            if (perf_q != '1) perf_d = perf_q + CNT_W'(1);
          end
        end else if (out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      ST_SQUASH: begin
        // Accepted requests are dropped; the pending entry may still drain.
        if (out_ready) out_valid_d = 1'b0;
        if (redirect_ack) begin
          redir_valid_d = 1'b0;
          state_d       = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      out_valid_q   <= 1'b0;
      res_q         <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      perf_q        <= '0;
    end else begin
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      res_q         <= res_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      perf_q        <= perf_d;
    end
  end

  assign out_valid        = out_valid_q;
  assign out_taken        = res_q.taken;
  assign out_mispredict   = res_q.mispredict;
  assign out_illegal      = res_q.illegal;
  assign out_target       = res_q.target;
  assign out_link         = res_q.link;
  assign redirect_valid   = redir_valid_q;
  assign redirect_pc      = redir_pc_q;
  assign perf_mispredicts = perf_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: transaction-level model checked every
// cycle, plus hand-computed literal expectations.
module tb_branch_resolve_unit;
  import rv32i_pkg::*;

  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_kind;
  logic [2:0]       in_funct3;
  logic [31:0]      in_pc, in_imm, in_rs1, in_rs2;
  logic             in_pred_taken;
  logic             out_valid;
  logic             out_ready;
  logic             out_taken, out_mispredict, out_illegal;
  logic [31:0]      out_target, out_link;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             redirect_ack;
  logic [CNT_W-1:0] perf_mispredicts;

  int total = 0;
  int bad   = 0;

  branch_resolve_unit #(.CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_kind          (in_kind),
    .in_funct3        (in_funct3),
    .in_pc            (in_pc),
    .in_imm           (in_imm),
    .in_rs1           (in_rs1),
    .in_rs2           (in_rs2),
    .in_pred_taken    (in_pred_taken),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_taken        (out_taken),
    .out_mispredict   (out_mispredict),
    .out_illegal      (out_illegal),
    .out_target       (out_target),
    .out_link         (out_link),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .redirect_ack     (redirect_ack),
    .perf_mispredicts (perf_mispredicts)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural meaning of one request, straight from the ISA rules.
  function automatic br_result_t ref_resolve(input logic [1:0] kind, input logic [2:0] f3,
                                             input logic [31:0] pc, input logic [31:0] imm,
                                             input logic [31:0] rs1, input logic [31:0] rs2,
                                             input logic pred);
    br_result_t r;
    logic t, ill;
    t = 1'b0;
    ill = 1'b0;
    r = '0;
    r.link   = pc + 32'd4;
    r.target = pc + imm;
    if (kind == KIND_BR) begin
      case (f3)
        3'd0:    t = (rs1 == rs2);
        3'd1:    t = (rs1 != rs2);
        3'd4:    t = ($signed(rs1) < $signed(rs2));
        3'd5:    t = ($signed(rs1) >= $signed(rs2));
        3'd6:    t = (rs1 < rs2);
        3'd7:    t = (rs1 >= rs2);
        default: ill = 1'b1;
      endcase
    end else if (kind == KIND_JAL) begin
      t = 1'b1;
    end else if (kind == KIND_JALR) begin
      t = 1'b1;
      r.target = (rs1 + imm) & 32'hFFFF_FFFE;
    end
    r.taken      = t;
    r.illegal    = ill;
    r.mispredict = (t != pred);
    return r;
  endfunction

  // Model state: one output slot, a pending redirect, a squash flag, a counter.
  logic        m_ov, m_rv, m_squash;
  br_result_t  m_res;
  logic [31:0] m_rpc;
  int unsigned m_perf;

  always @(posedge clk or negedge rst_n) begin
    br_result_t r;
    logic       take;
    if (!rst_n) begin
      m_ov = 1'b0; m_rv = 1'b0; m_squash = 1'b0; m_res = '0; m_rpc = '0; m_perf = 0;
    end else begin
      take = in_valid && (m_squash || !m_ov || out_ready);
      r = ref_resolve(in_kind, in_funct3, in_pc, in_imm, in_rs1, in_rs2, in_pred_taken);
      if (m_squash) begin
        if (out_ready) m_ov = 1'b0;
        if (redirect_ack) begin
          m_rv = 1'b0;
          m_squash = 1'b0;
        end
      end else if (take) begin
        m_ov = 1'b1;
        m_res = r;
        if (r.mispredict) begin
          m_rv = 1'b1;
          m_rpc = r.taken ? r.target : r.link;
          m_squash = 1'b1;
          if (m_perf < (32'd1 << CNT_W) - 1) m_perf++;
        end
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("mdl_in_ready", 32'(in_ready), 32'(rst_n && (m_squash || !m_ov || out_ready)));
    chk("mdl_out_valid", 32'(out_valid), 32'(m_ov));
    chk("mdl_redirect_valid", 32'(redirect_valid), 32'(m_rv));
    chk("mdl_perf", 32'(perf_mispredicts), 32'(CNT_W'(m_perf)));
    if (m_ov) begin
      chk("mdl_out_taken", 32'(out_taken), 32'(m_res.taken));
      chk("mdl_out_mispredict", 32'(out_mispredict), 32'(m_res.mispredict));
      chk("mdl_out_illegal", 32'(out_illegal), 32'(m_res.illegal));
      chk("mdl_out_target", out_target, m_res.target);
      chk("mdl_out_link", out_link, m_res.link);
    end
    if (m_rv) chk("mdl_redirect_pc", redirect_pc, m_rpc);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] kind, input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic pred);
    in_valid = 1'b1; in_kind = kind; in_funct3 = f3; in_pc = pc; in_imm = imm;
    in_rs1 = rs1; in_rs2 = rs2; in_pred_taken = pred;
  endtask

  logic [7:0] taken_mask [2];
  logic [31:0] pair_a [2];
  logic [31:0] pair_b [2];

  initial begin
    taken_mask[0] = 8'hA1; pair_a[0] = 32'd5;         pair_b[0] = 32'd5;
    taken_mask[1] = 8'h92; pair_a[1] = 32'hFFFF_FFFF; pair_b[1] = 32'd1;
    rst_n = 1'b0; in_valid = 1'b0; in_kind = '0; in_funct3 = '0; in_pc = '0; in_imm = '0;
    in_rs1 = '0; in_rs2 = '0; in_pred_taken = 1'b0; out_ready = 1'b1; redirect_ack = 1'b0;

    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_out_target", out_target, 32'd0);
    chk("rst_perf", 32'(perf_mispredicts), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Signed less-than taken against a not-taken prediction.
    drive(KIND_BR, 3'b100, 32'h100, 32'h40, 32'hFFFF_FFFF, 32'd0, 1'b0);
    step(); in_valid = 1'b0;
    chk("blt_taken", 32'(out_taken), 32'd1);
    chk("blt_mispredict", 32'(out_mispredict), 32'd1);
    chk("blt_redirect_valid", 32'(redirect_valid), 32'd1);
    chk("blt_redirect_pc", redirect_pc, 32'h140);
    chk("blt_perf", 32'(perf_mispredicts), 32'd1);
    redirect_ack = 1'b1;
    step(); redirect_ack = 1'b0;
    chk("blt_ack_drop", 32'(redirect_valid), 32'd0);

    // Same operands, unsigned: not taken, no redirect.
    drive(KIND_BR, 3'b110, 32'h180, 32'h40, 32'hFFFF_FFFF, 32'd0, 1'b0);
    step(); in_valid = 1'b0;
    chk("bltu_valid", 32'(out_valid), 32'd1);
    chk("bltu_taken", 32'(out_taken), 32'd0);
    chk("bltu_mispredict", 32'(out_mispredict), 32'd0);
    chk("bltu_no_redirect", 32'(redirect_valid), 32'd0);
    chk("bltu_link", out_link, 32'h184);

    // JALR target clears bit 0.
    drive(KIND_JALR, 3'b000, 32'h2000, 32'h2, 32'h1001, 32'd0, 1'b1);
    step(); in_valid = 1'b0;
    chk("jalr_target", out_target, 32'h1002);
    chk("jalr_link", out_link, 32'h2004);
    chk("jalr_taken", 32'(out_taken), 32'd1);
    chk("jalr_no_redirect", 32'(redirect_valid), 32'd0);

    // Reserved funct3.
    drive(KIND_BR, 3'b011, 32'h240, 32'h4, 32'd1, 32'd2, 1'b0);
    step(); in_valid = 1'b0;
    chk("illegal_flag", 32'(out_illegal), 32'd1);
    chk("illegal_taken", 32'(out_taken), 32'd0);
    chk("illegal_mispredict", 32'(out_mispredict), 32'd0);

    // Back-to-back sweep of every funct3 with correct predictions.
    for (int p = 0; p < 2; p++) begin
      for (int f = 0; f < 8; f++) begin
        drive(KIND_BR, 3'(f), 32'h1000 + 32'(f * 16), 32'h80, pair_a[p], pair_b[p],
              taken_mask[p][f]);
        step();
        chk($sformatf("sweep_taken_p%0d_f%0d", p, f), 32'(out_taken), 32'(taken_mask[p][f]));
        chk($sformatf("sweep_mispredict_p%0d_f%0d", p, f), 32'(out_mispredict), 32'd0);
      end
    end
    in_valid = 1'b0;

    // JAL mispredict, then three requests squashed and one in the ack cycle.
    drive(KIND_JAL, 3'b000, 32'h300, 32'h20, 32'd0, 32'd0, 1'b0);
    step();
    chk("jal_redirect_valid", 32'(redirect_valid), 32'd1);
    chk("jal_redirect_pc", redirect_pc, 32'h320);
    chk("jal_perf", 32'(perf_mispredicts), 32'd2);
    for (int i = 0; i < 3; i++) begin
      drive(KIND_BR, F3_BEQ, 32'h700 + 32'(i * 4), 32'h10, 32'd1, 32'd1, 1'b0);
      step();
      chk($sformatf("squash_out_valid_%0d", i), 32'(out_valid), 32'd0);
      chk($sformatf("squash_redirect_held_%0d", i), 32'(redirect_valid), 32'd1);
      chk($sformatf("squash_redirect_pc_%0d", i), redirect_pc, 32'h320);
      chk($sformatf("squash_in_ready_%0d", i), 32'(in_ready), 32'd1);
    end
    redirect_ack = 1'b1;
    step(); redirect_ack = 1'b0; in_valid = 1'b0;
    chk("ack_redirect_drop", 32'(redirect_valid), 32'd0);
    chk("ack_cycle_discard", 32'(out_valid), 32'd0);
    chk("squash_perf", 32'(perf_mispredicts), 32'd2);
    drive(KIND_BR, F3_BEQ, 32'h800, 32'h10, 32'd1, 32'd1, 1'b1);
    step(); in_valid = 1'b0;
    chk("resume_valid", 32'(out_valid), 32'd1);
    chk("resume_target", out_target, 32'h810);

    // Output backpressure.
    step();
    out_ready = 1'b0;
    drive(KIND_BR, F3_BEQ, 32'h400, 32'h10, 32'd5, 32'd5, 1'b1);
    step();
    drive(KIND_BR, F3_BNE, 32'h500, 32'h30, 32'd5, 32'd5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd0);
      chk($sformatf("bp_out_valid_%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp_target_stable_%0d", i), out_target, 32'h410);
      chk($sformatf("bp_link_stable_%0d", i), out_link, 32'h404);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
    step(); in_valid = 1'b0;
    chk("bp_b_valid", 32'(out_valid), 32'd1);
    chk("bp_b_link", out_link, 32'h504);
    chk("bp_b_taken", 32'(out_taken), 32'd0);
    step();
    chk("bp_drain", 32'(out_valid), 32'd0);

    // Reset asserted while a redirect is pending.
    drive(KIND_BR, F3_BNE, 32'h600, 32'h8, 32'd1, 32'd2, 1'b0);
    step(); in_valid = 1'b0;
    chk("pre_rst_redirect", 32'(redirect_valid), 32'd1);
    chk("pre_rst_redirect_pc", redirect_pc, 32'h608);
    chk("pre_rst_perf", 32'(perf_mispredicts), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_perf", 32'(perf_mispredicts), 32'd0);
    drive(KIND_BR, F3_BEQ, 32'h900, 32'h20, 32'd3, 32'd3, 1'b1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step(); in_valid = 1'b0;
    chk("post_rst_accept", 32'(out_valid), 32'd1);
    chk("post_rst_target", out_target, 32'h920);
    chk("post_rst_no_redirect", 32'(redirect_valid), 32'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
